spike_io_bank: RTL and testbench

SPIKE_IO_BANK -- requirements
Module: spike_io_bank

---
 rtl/spike_io_pkg.sv | 20 ++
 rtl/spike_io_ch.sv | 48 ++++
 rtl/spike_io_bank.sv | 124 ++++++++++++
 tb/tb_spike_io_bank.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spike_io_pkg.sv
// Shared register map, control/status bit positions and pulse counter sizing
// for the spike I/O bank.
package spike_io_pkg;

  // Offsets above the channel accumulators, which occupy 0..NUM_CH-1.
  localparam int REG_OUT_OFS  = 0;
  localparam int REG_CNT_OFS  = 1;
  localparam int REG_STAT_OFS = 2;
  localparam int REG_CTRL_OFS = 3;
  localparam int REG_TS_OFS   = 4;

  localparam int CTRL_PULSE_BIT  = 0;
  localparam int CTRL_IRQ_EN_BIT = 1;
  localparam int CTRL_W          = 2;
  localparam int STAT_PULSE_BIT  = 31;

  localparam int PULSE_CNT_W = 8;
  typedef logic [PULSE_CNT_W-1:0] pulse_cnt_t;

endpackage

// File: rtl/spike_io_ch.sv
// One spike channel: input stage, sticky OR accumulator with read-clear and,
// when SPIKE_IO_TIMESTAMP_EN is defined, a first-spike timestamp.
module spike_io_ch
  import spike_io_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] spike,
  input  logic              clr,
  output logic [DATA_W-1:0] acc
`ifdef SPIKE_IO_TIMESTAMP_EN
  ,
  input  logic [DATA_W-1:0] counter_in,
  output logic [DATA_W-1:0] ts
`endif
);

  logic [DATA_W-1:0] stage_q;

  // A read-clear loads only the staged bits, so a spike arriving with the
  // read survives into the next read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stage_q <= '0;
      acc     <= '0;
    end else begin
      stage_q <= spike;
      acc     <= clr ? stage_q : (acc | stage_q);
    end
  end

`ifdef SPIKE_IO_TIMESTAMP_EN
  // counter_in is what the top's counter stage loads on this same edge, so the
  // timestamp equals the registered counter in the first nonzero cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ts <= '0;
    end else if (clr) begin
      ts <= (|stage_q) ? counter_in : '0;
    end else if ((acc == '0) && (|stage_q)) begin
      ts <= counter_in;
    end
  end
`endif

endmodule

// File: rtl/spike_io_bank.sv
// Memory-mapped spike I/O bank: per-channel sticky accumulators, level/pulse
// spike output, status/control and level irq. Option: SPIKE_IO_TIMESTAMP_EN.
module spike_io_bank
  import spike_io_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int DATA_W    = 32,
  parameter int PULSE_CYC = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              addr,
  input  logic [DATA_W-1:0]        data_in,
  input  logic                     wren,
  input  logic                     rden,
  output logic [DATA_W-1:0]        data_out,
  output logic                     rd_valid,
  input  logic [NUM_CH*DATA_W-1:0] spike_in,
  output logic [DATA_W-1:0]        spike_data,
  input  logic [DATA_W-1:0]        counter_in,
  output logic                     irq
);

  localparam logic [31:0] A_OUT  = 32'(NUM_CH + REG_OUT_OFS);
  localparam logic [31:0] A_CNT  = 32'(NUM_CH + REG_CNT_OFS);
  localparam logic [31:0] A_STAT = 32'(NUM_CH + REG_STAT_OFS);
  localparam logic [31:0] A_CTRL = 32'(NUM_CH + REG_CTRL_OFS);
`ifdef SPIKE_IO_TIMESTAMP_EN
  localparam logic [31:0] A_TS   = 32'(NUM_CH + REG_TS_OFS);
  logic [DATA_W-1:0] ts [NUM_CH];
`endif

  logic [DATA_W-1:0] acc [NUM_CH];
  logic [NUM_CH-1:0] clr;
  logic [NUM_CH-1:0] pending;
  logic [DATA_W-1:0] cnt_q;
  logic [DATA_W-1:0] out_q;
  logic [DATA_W-1:0] status;
  logic [DATA_W-1:0] rd_mux;
  logic [CTRL_W-1:0] ctrl_q;
  pulse_cnt_t        pulse_cnt;
  logic              pulse_act;
  logic              wr_out;
  logic              wr_ctrl;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign clr[k] = rden && (addr == 32'(k));
    spike_io_ch #(.DATA_W(DATA_W)) u_ch (
      .clk        (clk),
      .reset      (reset),
      .spike      (spike_in[k*DATA_W +: DATA_W]),
      .clr        (clr[k]),
      .acc        (acc[k])
`ifdef SPIKE_IO_TIMESTAMP_EN
      ,
      .counter_in (counter_in),
      .ts         (ts[k])
`endif
    );
    assign pending[k] = |acc[k];
  end

  assign wr_out    = wren && (addr == A_OUT);
  assign wr_ctrl   = wren && (addr == A_CTRL);
  assign pulse_act = (pulse_cnt != '0);

  // A write in pulse mode (re)starts the count; the last count clears out_q.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      out_q     <= '0;
      ctrl_q    <= '0;
      pulse_cnt <= '0;
    end else begin
      cnt_q <= counter_in;
      if (wr_ctrl) ctrl_q <= data_in[CTRL_W-1:0];
      if (wr_out) begin
        out_q     <= data_in;
        pulse_cnt <= ctrl_q[CTRL_PULSE_BIT] ? pulse_cnt_t'(PULSE_CYC) : '0;
      end else if (pulse_act) begin
        pulse_cnt <= pulse_cnt - 1'b1;
        if (pulse_cnt == pulse_cnt_t'(1)) out_q <= '0;
      end
    end
  end

  assign spike_data = (ctrl_q[CTRL_PULSE_BIT] && !pulse_act) ? '0 : out_q;
  assign irq        = ctrl_q[CTRL_IRQ_EN_BIT] && (|pending);

  always_comb begin
    status                 = '0;
    status[NUM_CH-1:0]     = pending;
    status[STAT_PULSE_BIT] = pulse_act;
  end

  always_comb begin
    rd_mux = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (addr == 32'(k)) rd_mux = acc[k];
    end
    if (addr == A_OUT)  rd_mux = out_q;
    if (addr == A_CNT)  rd_mux = cnt_q;
    if (addr == A_STAT) rd_mux = status;
    if (addr == A_CTRL) rd_mux = DATA_W'(ctrl_q);
`ifdef SPIKE_IO_TIMESTAMP_EN
    for (int k = 0; k < NUM_CH; k++) begin
      if (addr == A_TS + 32'(k)) rd_mux = ts[k];
    end
`endif
  end

  // Read handshake: rden is a one-cycle strobe with no backpressure; rd_valid
  // pulses on the next cycle with data_out, which otherwise holds its value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rden;
      if (rden) data_out <= rd_mux;
    end
  end

endmodule

// File: tb/tb_spike_io_bank.sv
// Directed bench for spike_io_bank: table-driven register map vectors plus
// hand-written multi-cycle sequences (read-clear, pulse, irq, reset, timestamp).
module tb_spike_io_bank;

  localparam int NUM_CH = 4;
  localparam int DW     = 32;
  localparam int PC     = 3;
  localparam logic [31:0] A_OUT  = 32'd4;
  localparam logic [31:0] A_CNT  = 32'd5;
  localparam logic [31:0] A_STAT = 32'd6;
  localparam logic [31:0] A_CTRL = 32'd7;
  localparam logic [31:0] A_TS   = 32'd8;

  logic                 clk;
  logic                 reset;
  logic [31:0]          addr;
  logic [DW-1:0]        data_in;
  logic                 wren;
  logic                 rden;
  logic [DW-1:0]        data_out;
  logic                 rd_valid;
  logic [NUM_CH*DW-1:0] spike_in;
  logic [DW-1:0]        spike_data;
  logic [DW-1:0]        counter_in;
  logic                 irq;

  spike_io_bank #(.NUM_CH(NUM_CH), .DATA_W(DW), .PULSE_CYC(PC)) dut (
    .clk        (clk),
    .reset      (reset),
    .addr       (addr),
    .data_in    (data_in),
    .wren       (wren),
    .rden       (rden),
    .data_out   (data_out),
    .rd_valid   (rd_valid),
    .spike_in   (spike_in),
    .spike_data (spike_data),
    .counter_in (counter_in),
    .irq        (irq)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  int n_tests = 0;
  int n_fail  = 0;
  logic [DW-1:0] exp_q[$];

  typedef struct {
    logic        wr;
    logic [31:0] a;
    logic [31:0] wdata;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs [9];
  logic [DW-1:0] ts_exp;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic do_write(input logic [31:0] a, input logic [DW-1:0] d);
    addr    = a;
    data_in = d;
    wren    = 1'b1;
    tick();
    wren    = 1'b0;
    data_in = '0;
  endtask

  task automatic do_read(input logic [31:0] a, input logic [DW-1:0] exp, input string name);
    addr = a;
    rden = 1'b1;
    exp_q.push_back(exp);
    tick();
    rden = 1'b0;
    check({name, "_valid"}, DW'(rd_valid), 1);
    check(name, data_out, exp_q.pop_front());
  endtask

  task automatic set_spike(input int k, input logic [DW-1:0] v);
    spike_in = '0;
    spike_in[k*DW +: DW] = v;
  endtask

  initial begin
    reset      = 1'b0;
    addr       = '0;
    data_in    = '0;
    wren       = 1'b0;
    rden       = 1'b0;
    spike_in   = '0;
    counter_in = '0;

    vecs[0] = '{1'b1, A_OUT,      32'h1234_5678, 32'h1234_5678, "out_rw"};
    vecs[1] = '{1'b1, A_CTRL,     32'hFFFF_FFFC, 32'h0,         "ctrl_rsvd"};
    vecs[2] = '{1'b1, A_CTRL,     32'h2,         32'h2,         "ctrl_irq_en"};
    vecs[3] = '{1'b1, A_CTRL,     32'h0,         32'h0,         "ctrl_clear"};
    vecs[4] = '{1'b1, A_STAT,     32'hFFFF,      32'h0,         "stat_ro"};
    vecs[5] = '{1'b1, 32'd100,    32'hDEAD,      32'h0,         "unmapped"};
    vecs[6] = '{1'b1, A_CNT,      32'h1,         32'h55,        "cnt_ro"};
    vecs[7] = '{1'b1, 32'd0,      32'hFF,        32'h0,         "ch0_ro"};
    vecs[8] = '{1'b1, A_TS + 1,   32'hFF,        32'h0,         "ts_idle"};

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    tick();
    check("rst_data_out", data_out, 0);
    check("rst_rd_valid", DW'(rd_valid), 0);
    check("rst_spike_data", spike_data, 0);
    check("rst_irq", DW'(irq), 0);

    counter_in = 32'h55;
    for (int i = 0; i < 9; i++) begin
      if (vecs[i].wr) do_write(vecs[i].a, vecs[i].wdata);
      do_read(vecs[i].a, vecs[i].exp, vecs[i].name);
    end

    repeat (4) tick();
    check("level_hold", spike_data, 32'h1234_5678);

    // write and read of the same address in one cycle
    addr = A_OUT; data_in = 32'hBEEF; wren = 1'b1; rden = 1'b1;
    tick();
    wren = 1'b0; rden = 1'b0;
    check("wr_rd_same_old", data_out, 32'h1234_5678);
    do_read(A_OUT, 32'hBEEF, "wr_rd_same_new");

    // sticky accumulate and read-clear on channel 1
    set_spike(1, 32'h1); tick();
    set_spike(1, 32'h4); tick();
    spike_in = '0; tick(); tick();
    do_read(32'd1, 32'h5, "sticky_or");
    do_read(32'd1, 32'h0, "reread_clear");

    // read-clear coinciding with new spike bits on channel 0
    set_spike(0, 32'h2); tick();
    spike_in = '0; tick(); tick();
    set_spike(0, 32'h8); tick();
    spike_in = '0;
    do_read(32'd0, 32'h2, "collide_old");
    do_read(32'd0, 32'h8, "collide_new");
    tick();
    check("data_out_hold", data_out, 32'h8);
    check("rd_valid_low", DW'(rd_valid), 0);

    // first-spike timestamp on channel 2, later spikes must not move it
`ifdef SPIKE_IO_TIMESTAMP_EN
    ts_exp = 32'd101;
`else
    ts_exp = 32'd0;
`endif
    counter_in = 32'd100; set_spike(2, 32'h10); tick();
    counter_in = 32'd101; spike_in = '0; tick();
    counter_in = 32'd102; set_spike(2, 32'h20); tick();
    counter_in = 32'd103; spike_in = '0; tick(); tick();
    do_read(A_TS + 2, ts_exp, "ts_capture");
    do_read(A_STAT, 32'h4, "stat_pending");
    do_read(A_CNT, 32'd103, "cnt_reg");
    check("irq_masked", DW'(irq), 0);
    do_read(32'd2, 32'h30, "ch2_accum");
    do_read(A_TS + 2, 32'h0, "ts_cleared");
    do_read(A_STAT, 32'h0, "stat_clear");

    // pulse mode
    do_write(A_CTRL, 32'h1);
    do_write(A_OUT, 32'hA5);
    for (int i = 0; i < 4; i++) begin
      check("pulse_data", spike_data, (i < 3) ? 32'hA5 : 32'h0);
      addr = A_STAT; rden = 1'b1;
      tick();
      rden = 1'b0;
      check("pulse_stat31", DW'(data_out[31]), (i < 3) ? 32'd1 : 32'd0);
    end
    do_read(A_OUT, 32'h0, "pulse_out_cleared");

    do_write(A_OUT, 32'h11);
    do_write(A_OUT, 32'h22);
    for (int i = 0; i < 4; i++) begin
      check("pulse_restart", spike_data, (i < 3) ? 32'h22 : 32'h0);
      tick();
    end

    // interrupt on channel 3
    do_write(A_CTRL, 32'h2);
    set_spike(3, 32'h1); tick();
    spike_in = '0;
    check("irq_early", DW'(irq), 0);
    tick();
    check("irq_set", DW'(irq), 1);
    addr = 32'd3; rden = 1'b1;
    tick();
    rden = 1'b0;
    check("irq_ch3_data", data_out, 32'h1);
    check("irq_clear", DW'(irq), 0);

    // reset in the middle of a pulse with a pending channel
    do_write(A_CTRL, 32'h3);
    set_spike(0, 32'hF); tick();
    spike_in = '0; tick(); tick();
    do_write(A_OUT, 32'h77);
    check("pre_reset_pulse", spike_data, 32'h77);
    check("pre_reset_irq", DW'(irq), 1);
    #2;
    reset = 1'b0;
    #1;
    check("reset_async_spike", spike_data, 0);
    check("reset_async_irq", DW'(irq), 0);
    check("reset_async_data_out", data_out, 0);
    repeat (2) @(posedge clk);
    #1;
    counter_in = '0;
    reset = 1'b1;
    tick();
    check("post_reset_spike", spike_data, 0);
    for (int a = 0; a < NUM_CH + 8; a++) begin
      do_read(32'(a), 32'h0, "post_reset_reg");
    end
    check("post_reset_irq", DW'(irq), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
